// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with parallel load, cascade terminal count
// and a registered full-range wrap pulse. Nibble i of q is decimal digit i.
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] cnt_next;
  logic [4*DIGITS-1:0] load_clean;
  logic                load_bad;
  logic                all_nine;
  logic                all_zero;
  logic                carry;
  logic [3:0]          d;
  logic [3:0]          lv;

  always_comb begin
    cnt_next   = q;
    load_clean = '0;
    load_bad   = 1'b0;
    all_nine   = 1'b1;
    all_zero   = 1'b1;
    carry      = 1'b1;
    d          = 4'd0;
    lv         = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = q[4*i +: 4];
      // carry means every lower digit sits at its rollover value for this direction
      if (carry) begin
        if (up) cnt_next[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
        else    cnt_next[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
      end
      carry    = carry & (up ? (d == 4'd9) : (d == 4'd0));
      all_nine = all_nine & (d == 4'd9);
      all_zero = all_zero & (d == 4'd0);
      lv = load_val[4*i +: 4];
      if (lv > 4'd9) load_bad = 1'b1;
      else           load_clean[4*i +: 4] = lv;
    end
  end

  assign tc = en & (up ? all_nine : all_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      q        <= load_clean;
      load_err <= load_bad;
      wrap     <= 1'b0;
    end else if (en) begin
      q    <= cnt_next;
      wrap <= tc;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Bench for bcd_counter (DIGITS=2): directed plan sequences followed by random
// traffic, checked against an integer-valued decimal model.
module tb_bcd_counter;
  localparam int DIGITS = 2;
  localparam int W      = 4*DIGITS;
  localparam int MOD    = 100;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         load_err;

  bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state: plain decimal integer
  int m_val   = 0;
  bit m_wrap  = 1'b0;
  bit m_lerr  = 1'b0;
  bit m_known = 1'b0;

  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int x);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = x;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // decimal value of a load word with non-decimal digits treated as 0
  function automatic int scrub_val(input logic [W-1:0] v, output bit bad);
    int acc;
    int scale;
    int nib;
    acc = 0;
    scale = 1;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = int'(v[4*i +: 4]);
      if (nib > 9) begin
        bad = 1'b1;
        nib = 0;
      end
      acc += nib * scale;
      scale *= 10;
    end
    return acc;
  endfunction

  // driver: apply inputs, check tc, clock once, check registered outputs
  task automatic drive(input bit r, input bit l, input bit e, input bit u, input logic [W-1:0] lv);
    bit bad;
    int nv;
    rst = r; load = l; en = e; up = u; load_val = lv;
    #1;
    if (m_known)
      check("tc", 32'(tc), 32'(e && (u ? (m_val == MOD-1) : (m_val == 0))));
    if (r) begin
      m_val = 0; m_wrap = 1'b0; m_lerr = 1'b0; m_known = 1'b1;
    end else if (l) begin
      nv = scrub_val(lv, bad);
      m_val = nv; m_lerr = bad; m_wrap = 1'b0;
    end else if (e) begin
      if (u) begin
        m_wrap = (m_val == MOD-1);
        m_val  = (m_val + 1) % MOD;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + MOD - 1) % MOD;
      end
    end else begin
      m_wrap = 1'b0;
    end
    exp_q.push_back(to_bcd(m_val));
    @(posedge clk);
    #1;
    if (m_known) begin
      check("q", 32'(q), 32'(exp_q.pop_front()));
      check("wrap", 32'(wrap), 32'(m_wrap));
      check("load_err", 32'(load_err), 32'(m_lerr));
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;
    @(posedge clk);
    #1;

    // reset dominates load/en, then count from 0
    drive(1, 1, 1, 1, 8'h55);
    drive(1, 1, 1, 1, 8'h55);
    drive(0, 0, 1, 1, 8'h00);

    // up count with carry
    drive(0, 1, 0, 1, 8'h08);
    repeat (3) drive(0, 0, 1, 1, 8'h00);

    // up wrap
    drive(0, 1, 0, 1, 8'h98);
    repeat (3) drive(0, 0, 1, 1, 8'h00);

    // down wrap
    drive(0, 1, 0, 0, 8'h01);
    repeat (3) drive(0, 0, 1, 0, 8'h00);

    // bad load, good load, reset beats load
    drive(0, 1, 1, 1, 8'h3C);
    drive(0, 1, 0, 1, 8'h42);
    drive(1, 1, 0, 1, 8'h42);

    // hold then direction changes
    drive(0, 1, 0, 1, 8'h47);
    repeat (5) drive(0, 0, 0, 1, 8'h00);
    drive(0, 0, 1, 1, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h00);

    // random traffic, biased toward counting and occasional near-wrap loads
    for (int k = 0; k < 600; k++) begin
      logic [W-1:0] lv;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      lv = W'($urandom);
      else if (sel == 1) lv = to_bcd(($urandom_range(0, 1) == 1) ? MOD-1 : 0);
      else               lv = to_bcd($urandom_range(0, MOD-1));
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 1) == 1),
            lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Synchronous multi-digit BCD up/down counter that drives the 4-bit q input of BCD_to_7_segment. It supplies one 4-bit nibble per decoder instance.
- Digit 0 (q[3:0]) is the least significant digit. Each digit is always in the range 0..9.
- Provides parallel load, count enable, a combinational terminal-count output for cascading counters, and a registered wrap pulse.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); the output width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; advances the counter by one per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  value to load; nibble i is digit i.
- q  output  4*DIGITS  current count, registered; nibble i feeds decoder i.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse on full-range wrap.
- load_err  output  1  registered; flags a load that contained a non-BCD nibble.

Behaviour:
- Reset is synchronous and active-high: on the clk edge with rst=1, q=0, wrap=0 and load_err=0.
- Priority per edge is rst > load > en. With none of them asserted, q holds, wrap=0 and load_err holds.
- Load: on a clock edge with load=1, each nibble of load_val is checked.
  - A nibble of 0..9 is copied to the corresponding digit.
  - A nibble above 9 (A..F) is stored as 0 in that digit.
  - load_err is set to 1 if any nibble was above 9, else 0. It keeps that value until the next load or reset.
  - wrap=0 on a load cycle. en is ignored on a load cycle.
- Count up (en=1, up=1):
  - Digit 0 always steps.
  - Digit i>0 steps only when every lower digit equals 9.
  - A stepping digit goes n->n+1, and 9->0.
- Count down (en=1, up=0):
  - Digit 0 always steps.
  - Digit i>0 steps only when every lower digit equals 0.
  - A stepping digit goes n->n-1, and 0->9.
- The new q is visible one clock after the enabling edge. Latency is 1 cycle.
- tc is combinational: tc = en & (up ? all digits==9 : all digits==0). Higher counter instances use tc as their en.
- wrap goes high for exactly one cycle after the edge that changes q from all-9 to all-0 (up) or from all-0 to all-9 (down). Otherwise wrap=0.
- Direction change mid-count is allowed. up is sampled on each edge with no extra state, so 05 counting up and then switched to down produces 06 then 05.
- Digits are never outside 0..9 after reset, so no other illegal states are reachable. Non-BCD load nibbles are scrubbed to 0 as described under Load.
- Reset takes effect on the next edge regardless of load/en/up. Asserting it mid-count or mid-wrap clears wrap on that edge.
- en held low: q is frozen and tc=0. load_err is unaffected.

Test Plan (DIGITS=2):
- Reset: rst=1 for 2 cycles with en=1 and load=1 -> q=8'h00, wrap=0, load_err=0. Release rst with en=1 and up=1 -> q=01 one cycle later.
- Up count with carry: load 8'h08, then en=1, up=1 for 3 cycles -> q=09, 10, 11. tc=0 throughout.
- Up wrap: load 8'h98, then en=1, up=1 -> q=99 with tc=1; next edge q=00 and wrap=1 for exactly one cycle; next edge q=01 and wrap=0.
- Down wrap: load 8'h01, then en=1, up=0 -> q=00 with tc=1; next edge q=99 and wrap=1; next edge q=98.
- Bad load and priority: load=1 with load_val=8'h3C and en=1 -> q=30, load_err=1. Then load=1 with load_val=8'h42 -> q=42, load_err=0. rst=1 together with load=1 -> q=00.
- Hold and direction change: from q=47 with en=0 for 5 cycles -> q stays 47 and tc=0. Then en=1 with up toggling 1,0,1 -> q=48, 47, 48.
